// File: rtl/vga_span_plotter.sv
// Span/clear pixel generator feeding vga_adapter: queues column spans, emits one plot per clock.
// Optional build macro SPAN_PLOTTER_CLIP_EN enables on-screen clipping of spans at pop time.
module vga_span_plotter #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [X_BITS-1:0]      req_x,
    input  logic [Y_BITS-1:0]      req_y0,
    input  logic [Y_BITS-1:0]      req_y1,
    input  logic [COLOUR_BITS-1:0] req_colour,
    input  logic                   clear_start,
    input  logic [COLOUR_BITS-1:0] clear_colour,
    output logic                   clear_done,
    output logic                   busy,
    output logic [X_BITS-1:0]      vga_x,
    output logic [Y_BITS-1:0]      vga_y,
    output logic [COLOUR_BITS-1:0] vga_colour,
    output logic                   vga_write
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPAN  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [X_BITS-1:0] X_MAX    = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX    = Y_BITS'(SCREEN_H - 1);
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [X_BITS-1:0]      x;
        logic [Y_BITS-1:0]      y0;
        logic [Y_BITS-1:0]      y1;
        logic [COLOUR_BITS-1:0] colour;
    } span_t;

    span_t                   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count, count_n;
    logic [1:0]              state, state_n;
    logic                    clear_pending;
    logic [COLOUR_BITS-1:0]  clr_colour;
    logic [Y_BITS-1:0]       cur_y1, y1_n;
    logic [X_BITS-1:0]       x_n;
    logic [Y_BITS-1:0]       y_n;
    logic [COLOUR_BITS-1:0]  c_n;
    logic                    w_n;

    span_t             head;
    logic [Y_BITS-1:0] head_y1;
    logic              head_drop;
    logic              empty, push, pop, span_end, clear_last, do_clear;

    assign head = mem[rd_ptr];

`ifdef SPAN_PLOTTER_CLIP_EN
    always_comb begin
        head_y1   = (head.y1 > Y_MAX) ? Y_MAX : head.y1;
        head_drop = (head.x > X_MAX) || (head.y0 > Y_MAX) || (head.y0 > head_y1);
    end
`else
    always_comb begin
        head_y1   = head.y1;
        head_drop = head.y0 > head.y1;
    end
`endif

    assign empty      = (count == '0);
    assign push       = req_valid && req_ready;
    assign span_end   = (state == S_SPAN) && (vga_y == cur_y1);
    assign clear_last = (state == S_CLEAR) && (vga_x == X_MAX) && (vga_y == Y_MAX);
    // A pending clear always wins over the queue at a decision point.
    assign do_clear   = clear_pending && ((state == S_IDLE) || span_end);
    assign pop        = !empty && !clear_pending &&
                        ((state == S_IDLE) || span_end || clear_last);
    assign count_n    = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign busy       = (state != S_IDLE) || !empty;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {req_x, req_y0, req_y1, req_colour};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            req_ready <= (count_n != FULL_CNT);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clear_pending <= 1'b0;
            clr_colour    <= '0;
        end else if (clear_start && !clear_pending && state != S_CLEAR) begin
            clear_pending <= 1'b1;
            clr_colour    <= clear_colour;
        end else if (do_clear) begin
            clear_pending <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = vga_x;
        y_n     = vga_y;
        c_n     = vga_colour;
        w_n     = vga_write;
        y1_n    = cur_y1;
        if (do_clear) begin
            state_n = S_CLEAR;
            x_n     = '0;
            y_n     = '0;
            c_n     = clr_colour;
            w_n     = 1'b1;
        end else if (pop) begin
            if (head_drop) begin
                state_n = S_IDLE;
                w_n     = 1'b0;
            end else begin
                state_n = S_SPAN;
                x_n     = head.x;
                y_n     = head.y0;
                c_n     = head.colour;
                w_n     = 1'b1;
                y1_n    = head_y1;
            end
        end else if (span_end || clear_last) begin
            state_n = S_IDLE;
            w_n     = 1'b0;
        end else if (state == S_SPAN) begin
            y_n = vga_y + Y_BITS'(1);
        end else if (state == S_CLEAR) begin
            if (vga_x == X_MAX) begin
                x_n = '0;
                y_n = vga_y + Y_BITS'(1);
            end else begin
                x_n = vga_x + X_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_write  <= 1'b0;
            cur_y1     <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            vga_x      <= x_n;
            vga_y      <= y_n;
            vga_colour <= c_n;
            vga_write  <= w_n;
            cur_y1     <= y1_n;
            clear_done <= clear_last;
        end
    end

endmodule

// File: tb/tb_vga_span_plotter.sv
// Directed bench for vga_span_plotter at default parameters; clip cases follow SPAN_PLOTTER_CLIP_EN.
module tb_vga_span_plotter;
    logic       clock = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y0, req_y1;
    logic [2:0] req_colour;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       clear_done;
    logic       busy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    int checks = 0;
    int errors = 0;

    vga_span_plotter dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y0(req_y0), .req_y1(req_y1), .req_colour(req_colour),
        .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
        .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pk(input logic w, input logic [7:0] x,
                                       input logic [6:0] y, input logic [2:0] c);
        return {13'd0, w, x, y, c};
    endfunction

    function automatic logic [31:0] outs();
        return pk(vga_write, vga_x, vga_y, vga_colour);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [6:0] y0, input logic [6:0] y1,
                        input logic [2:0] c);
        req_x = x; req_y0 = y0; req_y1 = y1; req_colour = c; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_count(input int cyc, output int nw, output logic [31:0] first,
                             output logic [31:0] last);
        nw = 0; first = '0; last = '0;
        for (int k = 0; k < cyc; k++) begin
            tick();
            if (vga_write) begin
                if (nw == 0) first = outs();
                last = outs();
                nw++;
            end
        end
    endtask

    initial begin
        int n, i, mism, gap, done_cnt, done_at, nw;
        logic rdy, saw_full, sent, cs2;
        logic [31:0] first, last, e;
        logic [31:0] prio [5];

        resetn = 1'b0; req_valid = 1'b0; req_x = '0; req_y0 = '0; req_y1 = '0;
        req_colour = '0; clear_start = 1'b0; clear_colour = '0;
        repeat (3) tick();
        check("reset_outs", outs(), 32'd0);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_busy", {30'd0, busy, clear_done}, 32'd0);
        resetn = 1'b1;
        tick();
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // single span: first write one cycle after acceptance
        send(8'd10, 7'd5, 7'd8, 3'd3);
        check("span_latency", {31'd0, vga_write}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("span_pix", outs(), pk(1'b1, 8'd10, 7'(5 + k), 3'd3));
        end
        tick();
        check("span_end_write", {31'd0, vga_write}, 32'd0);
        check("span_end_busy", {31'd0, busy}, 32'd0);

        // long span keeps the FSM occupied so five 2-pixel spans fill the queue
        send(8'd30, 7'd0, 7'd19, 3'd5);
        n = 0; i = 0; mism = 0; gap = 0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (i < 5) begin
                req_x = 8'(20 + i); req_y0 = 7'd10; req_y1 = 7'd11; req_colour = 3'(i + 1);
                req_valid = 1'b1;
            end else req_valid = 1'b0;
            rdy = req_ready;
            if (!rdy) saw_full = 1'b1;
            tick();
            if (req_valid && rdy) i++;
            if (vga_write) begin
                if (n < 20) e = pk(1'b1, 8'd30, 7'(n), 3'd5);
                else e = pk(1'b1, 8'(20 + (n - 20) / 2), 7'(10 + (n - 20) % 2), 3'(1 + (n - 20) / 2));
                if (outs() !== e) mism++;
                n++;
            end else if (n > 0 && n < 30) gap++;
        end
        req_valid = 1'b0;
        check("b2b_full_seen", {31'd0, saw_full}, 32'd1);
        check("b2b_all_pushed", i, 5);
        check("b2b_writes", n, 30);
        check("b2b_order", mism, 0);
        check("b2b_no_gap", gap, 0);
        check("b2b_drained", {30'd0, busy, req_ready}, 32'd1);

        // clear with a span queued mid-clear and a second clear_start that must be ignored
        clear_colour = 3'd1; clear_start = 1'b1;
        tick();
        clear_start = 1'b0; clear_colour = 3'd0;
        check("clear_latency", {31'd0, vga_write}, 32'd0);
        n = 0; mism = 0; gap = 0; done_cnt = 0; done_at = -1; sent = 1'b0; cs2 = 1'b0;
        for (int cyc = 0; cyc < 19215; cyc++) begin
            if (n == 100 && !sent) begin
                req_x = 8'd5; req_y0 = 7'd1; req_y1 = 7'd2; req_colour = 3'd6;
                req_valid = 1'b1; sent = 1'b1;
            end else req_valid = 1'b0;
            if (n == 200 && !cs2) begin
                clear_start = 1'b1; clear_colour = 3'd7; cs2 = 1'b1;
            end else clear_start = 1'b0;
            tick();
            if (clear_done) begin done_cnt++; done_at = n; end
            if (vga_write) begin
                if (n < 19200) e = pk(1'b1, 8'(n % 160), 7'(n / 160), 3'd1);
                else if (n < 19202) e = pk(1'b1, 8'd5, 7'(1 + n - 19200), 3'd6);
                else e = '1;
                if (outs() !== e) mism++;
                n++;
            end else if (n > 0 && n < 19202) gap++;
        end
        req_valid = 1'b0; clear_start = 1'b0;
        check("clear_writes", n, 19202);
        check("clear_order", mism, 0);
        check("clear_no_gap", gap, 0);
        check("clear_done_cnt", done_cnt, 1);
        check("clear_done_pos", done_at, 19200);
        check("clear_idle", {31'd0, busy}, 32'd0);

        // inverted span is discarded
        send(8'd50, 7'd9, 7'd2, 3'd4);
        run_count(6, nw, first, last);
        check("degen_writes", nw, 0);
        check("degen_busy", {31'd0, busy}, 32'd0);

`ifdef SPAN_PLOTTER_CLIP_EN
        send(8'd170, 7'd0, 7'd3, 3'd5);
        run_count(8, nw, first, last);
        check("clip_x_writes", nw, 0);
        send(8'd20, 7'd125, 7'd127, 3'd2);
        run_count(8, nw, first, last);
        check("clip_y0_writes", nw, 0);
        send(8'd20, 7'd110, 7'd127, 3'd2);
        run_count(25, nw, first, last);
        check("clip_y1_writes", nw, 10);
        check("clip_y1_first", first, pk(1'b1, 8'd20, 7'd110, 3'd2));
        check("clip_y1_last", last, pk(1'b1, 8'd20, 7'd119, 3'd2));
`else
        send(8'd170, 7'd0, 7'd3, 3'd5);
        run_count(10, nw, first, last);
        check("noclip_x_writes", nw, 4);
        check("noclip_x_first", first, pk(1'b1, 8'd170, 7'd0, 3'd5));
        check("noclip_x_last", last, pk(1'b1, 8'd170, 7'd3, 3'd5));
        send(8'd20, 7'd110, 7'd127, 3'd2);
        run_count(25, nw, first, last);
        check("noclip_y_writes", nw, 18);
        check("noclip_y_last", last, pk(1'b1, 8'd20, 7'd127, 3'd2));
`endif

        // clear requested mid-span runs right after the span finishes
        send(8'd40, 7'd0, 7'd5, 3'd2);
        tick();
        check("prio_pix0", outs(), pk(1'b1, 8'd40, 7'd0, 3'd2));
        tick();
        check("prio_pix1", outs(), pk(1'b1, 8'd40, 7'd1, 3'd2));
        clear_colour = 3'd1; clear_start = 1'b1;
        tick();
        clear_start = 1'b0; clear_colour = 3'd0;
        check("prio_pix2", outs(), pk(1'b1, 8'd40, 7'd2, 3'd2));
        prio[0] = pk(1'b1, 8'd40, 7'd3, 3'd2);
        prio[1] = pk(1'b1, 8'd40, 7'd4, 3'd2);
        prio[2] = pk(1'b1, 8'd40, 7'd5, 3'd2);
        prio[3] = pk(1'b1, 8'd0, 7'd0, 3'd1);
        prio[4] = pk(1'b1, 8'd1, 7'd0, 3'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("prio_seq", outs(), prio[k]);
        end

        // asynchronous reset in the middle of the clear
        repeat (50) tick();
        check("pre_reset_writing", {31'd0, vga_write}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_write", {31'd0, vga_write}, 32'd0);
        check("async_reset_state", {30'd0, busy, req_ready}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        run_count(10, nw, first, last);
        check("post_reset_writes", nw, 0);
        check("post_reset_state", {30'd0, busy, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
